// File: rtl/dice_tally.sv
// Dice roll tally: captures the settled throw after the button is released,
// keeps per-face, roll and sum counters, and flags illegal throws.
module dice_tally (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic [2:0]  throw,
  input  logic [2:0]  sel,
  output logic [2:0]  result,
  output logic        result_valid,
  output logic        double,
  output logic [7:0]  face_count,
  output logic [7:0]  roll_count,
  output logic [10:0] total,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    ROLLING,
    SETTLE,
    RESULT
  } state_t;

  state_t      state;
  logic [7:0]  cnt [6];
  logic        legal;
  logic [11:0] tsum;

  assign legal = (throw != 3'd0) && (throw != 3'd7);
  assign tsum  = {1'b0, total} + {9'd0, throw};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      result       <= 3'd0;
      result_valid <= 1'b0;
      double       <= 1'b0;
      roll_count   <= 8'd0;
      total        <= 11'd0;
      err          <= 1'b0;
      for (int i = 0; i < 6; i++) cnt[i] <= 8'd0;
    end else begin
      result_valid <= 1'b0;
      double       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (button) state <= ROLLING;
        end
        ROLLING: begin
          if (!button) state <= SETTLE;
        end
        SETTLE: begin
          // button is ignored here; the throw is captured regardless
          if (legal) begin
            state        <= RESULT;
            result       <= throw;
            result_valid <= 1'b1;
            // result is 0 only before the first legal capture
            double       <= (throw == result);
            if (roll_count != 8'hff) roll_count <= roll_count + 8'd1;
            total <= tsum[11] ? 11'h7ff : tsum[10:0];
            for (int i = 0; i < 6; i++)
              if (throw == 3'(i + 1) && cnt[i] != 8'hff)
                cnt[i] <= cnt[i] + 8'd1;
          end else begin
            state <= IDLE;
            err   <= 1'b1;
          end
        end
        RESULT: begin
          state <= button ? ROLLING : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    face_count = 8'd0;
    case (sel)
      3'd1:    face_count = cnt[0];
      3'd2:    face_count = cnt[1];
      3'd3:    face_count = cnt[2];
      3'd4:    face_count = cnt[3];
      3'd5:    face_count = cnt[4];
      3'd6:    face_count = cnt[5];
      default: face_count = 8'd0;
    endcase
  end

endmodule
